mux_n_stage: RTL and testbench

- Parametrised N-input, registered select stage for the RISC-V pipeline (e.g. writeback result select, forwarding operand select).
- Picks one of NUM_IN data words and registers it behind a valid/ready handshake.
- A two-entry skid buffer lets in_ready be a pure register output, so downstream stalls never form a combinational path back upstream.
- Supports pipeline flush and flags out-of-range selects.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/mux_n.sv | 25 ++
 rtl/mux_n_stage.sv | 116 +++++++++++
 tb/tb_mux_n_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: machine word width and the registered-stage state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b01,
        FULL2 = 2'b10
    } stage_state_t;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 word selector; an out-of-range select yields zero with err set.
module mux_n #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]         in_sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_err
);

    // err stays set unless some in-range index matches the select
    always_comb begin
        out_data = '0;
        out_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_WIDTH'(k)) begin
                out_data = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                out_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_stage.sv
// Registered N:1 select stage with valid/ready handshake and a two-entry skid buffer.
module mux_n_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]         in_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_err,
    output logic                         out_valid,
    input  logic                         out_ready
);

    stage_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0]   main_data_q, main_data_d;
    logic                    main_err_q, main_err_d;
    logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
    logic                    skid_err_q, skid_err_d;

    logic [DATA_WIDTH-1:0]   sel_word;
    logic                    sel_err;
    logic                    accept;
    logic                    xfer;

    mux_n #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_mux (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (sel_word),
        .out_err  (sel_err)
    );

    // Handshake outputs depend on registered state only
    assign in_ready  = (state_q != FULL2);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                    state_d     = FULL1;
                end
            end
            FULL1: begin
                if (accept && xfer) begin
                    main_data_d = sel_word;
                    main_err_d  = sel_err;
                end else if (xfer) begin
                    state_d     = EMPTY;
                end else if (accept) begin
                    skid_data_d = sel_word;
                    skid_err_d  = sel_err;
                    state_d     = FULL2;
                end
            end
            FULL2: begin
                if (xfer) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = FULL1;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops every held beat and any same-cycle accept; stale data is left in place
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            main_err_d  = main_err_q;
            skid_data_d = skid_data_q;
            skid_err_d  = skid_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_mux_n_stage.sv
// Bench for mux_n_stage: power-of-two (4) and non-power-of-two (3) instances against a queue model.
module tb_mux_n_stage;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] w [4];
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic [127:0] in_data4;
    logic [95:0]  in_data3;

    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_data4;
    logic        in_ready3, out_valid3, out_err3;
    logic [31:0] out_data3;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t q4[$];
    beat_t q3[$];

    assign in_data4 = {w[3], w[2], w[1], w[0]};
    assign in_data3 = {w[2], w[1], w[0]};

    always #5 clk = ~clk;

    mux_n_stage #(
        .DATA_WIDTH (32),
        .NUM_IN     (4)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data4),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .flush     (flush),
        .out_data  (out_data4),
        .out_err   (out_err4),
        .out_valid (out_valid4),
        .out_ready (out_ready)
    );

    mux_n_stage #(
        .DATA_WIDTH (32),
        .NUM_IN     (3)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .flush     (flush),
        .out_data  (out_data3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference select: word s if it exists among n inputs, else zero with error
    function automatic beat_t ref_sel(input int n, input int s);
        beat_t b;
        if (s < n) begin
            b.d = w[s];
            b.e = 1'b0;
        end else begin
            b.d = '0;
            b.e = 1'b1;
        end
        return b;
    endfunction

    task automatic check_dut(input string tag, input logic rdy, input logic vld,
                             input logic [31:0] d, input logic e, input int sz, input beat_t fr);
        check({tag, ".in_ready"},  {31'b0, rdy}, {31'b0, (sz < 2)});
        check({tag, ".out_valid"}, {31'b0, vld}, {31'b0, (sz > 0)});
        if (sz > 0) begin
            check({tag, ".out_data"}, d, fr.d);
            check({tag, ".out_err"},  {31'b0, e}, {31'b0, fr.e});
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic cycle();
        bit    rdy4, vld4, rdy3, vld3;
        beat_t b4, b3, f;
        rdy4 = (q4.size() < 2);
        vld4 = (q4.size() > 0);
        rdy3 = (q3.size() < 2);
        vld3 = (q3.size() > 0);
        b4 = ref_sel(4, int'(in_sel));
        b3 = ref_sel(3, int'(in_sel));
        @(posedge clk);
        if (!rst_n || flush) begin
            q4.delete();
            q3.delete();
        end else begin
            if (vld4 && out_ready) void'(q4.pop_front());
            if (in_valid && rdy4) q4.push_back(b4);
            if (vld3 && out_ready) void'(q3.pop_front());
            if (in_valid && rdy3) q3.push_back(b3);
        end
        #1;
        f = (q4.size() > 0) ? q4[0] : '0;
        check_dut("dut4", in_ready4, out_valid4, out_data4, out_err4, q4.size(), f);
        f = (q3.size() > 0) ? q3[0] : '0;
        check_dut("dut3", in_ready3, out_valid3, out_data3, out_err3, q3.size(), f);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".out_valid"}, {31'b0, out_valid4}, 32'd0);
        check({name, ".out_data"},  out_data4, 32'd0);
        check({name, ".out_err"},   {31'b0, out_err4}, 32'd0);
        check({name, ".in_ready"},  {31'b0, in_ready4}, 32'd1);
    endtask

    vec_t tbl [6];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_sel = '0;
        for (int i = 0; i < 4; i++) w[i] = '0;

        // Reset held two cycles while upstream offers a beat
        in_valid = 1'b1; in_sel = 2'd2; w[2] = 32'hDEADBEEF;
        cycle(); cycle();
        check_reset_outputs("reset");

        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("first.out_valid", {31'b0, out_valid4}, 32'd1);
        check("first.out_data", out_data4, 32'hDEADBEEF);
        cycle();
        check("first.drained", {31'b0, out_valid4}, 32'd0);

        // Streaming: one beat per cycle, no bubbles
        for (int k = 0; k < 4; k++) w[k] = 32'(k) * 32'h11111111;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = 2'(i % 4);
            cycle();
            check("stream.data", out_data4, 32'(i % 4) * 32'h11111111);
            check("stream.in_ready", {31'b0, in_ready4}, 32'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        w[0] = 32'h1; cycle();
        w[0] = 32'h2; cycle();
        in_valid = 1'b0;
        check("skid.in_ready", {31'b0, in_ready4}, 32'd0);
        check("skid.hold_A", out_data4, 32'h1);
        cycle();
        check("skid.stable_A", out_data4, 32'h1);
        out_ready = 1'b1;
        cycle();
        check("skid.B", out_data4, 32'h2);
        check("skid.ready_back", {31'b0, in_ready4}, 32'd1);
        cycle();
        check("skid.empty", {31'b0, out_valid4}, 32'd0);

        // Flush while full, with a competing beat C
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        w[0] = 32'hA; cycle();
        w[0] = 32'hB; cycle();
        w[0] = 32'hC; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.out_valid", {31'b0, out_valid4}, 32'd0);
        check("flush.in_ready", {31'b0, in_ready4}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush.nothing_out", {31'b0, out_valid4}, 32'd0);
        end

        // Select table for the 3-input instance, including out-of-range selects
        w[0] = 32'hCAFE0000; w[1] = 32'h12345678; w[2] = 32'h0BADF00D; w[3] = 32'hFFFFFFFF;
        tbl[0] = '{2'd0, 32'hCAFE0000, 1'b0};
        tbl[1] = '{2'd3, 32'h00000000, 1'b1};
        tbl[2] = '{2'd1, 32'h12345678, 1'b0};
        tbl[3] = '{2'd2, 32'h0BADF00D, 1'b0};
        tbl[4] = '{2'd3, 32'h00000000, 1'b1};
        tbl[5] = '{2'd1, 32'h12345678, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = tbl[i].sel;
            cycle();
            check("tbl.out_valid", {31'b0, out_valid3}, 32'd1);
            check("tbl.out_data", out_data3, tbl[i].exp_data);
            check("tbl.out_err", {31'b0, out_err3}, {31'b0, tbl[i].exp_err});
        end
        in_valid = 1'b0;
        cycle();

        // Reset with two beats held and downstream ready
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        cycle(); cycle();
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        cycle();
        check("midreset.stays_empty", {31'b0, out_valid4}, 32'd0);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            in_sel    = 2'($urandom_range(3, 0));
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(24, 0) == 0);
            rst_n     = ($urandom_range(49, 0) != 0);
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
